// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the 5-stage pipeline control
//               logic. It holds the hazard FSM state encoding, the
//               forwarding-select codes, and a small helper that decides
//               whether a write-back register feeds a source operand.
// Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    // Hazard controller state.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    // ALU operand source selects.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // A producer forwards to a consumer only when it really writes a
    // register, that register is not r0, and the register numbers match.
    function automatic logic fwd_hit(input logic       wr_en,
                                     input logic [4:0] wr_reg,
                                     input logic [4:0] src_reg);
        return wr_en && (wr_reg != 5'd0) && (wr_reg == src_reg);
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_unit
// Description : Combinational EX-stage operand forwarding selects. For each
//               ALU operand it picks the EX/MEM result, the MEM/WB result, or
//               the register file, with EX/MEM taking precedence because it
//               holds the younger value.
// Ports       : i_id_ex_rs, i_id_ex_rt          source registers in ID/EX
//               i_ex_mem_reg_write, i_ex_mem_wb_reg  EX/MEM producer
//               i_mem_wb_reg_write, i_mem_wb_wb_reg  MEM/WB producer
//               o_fwd_a, o_fwd_b                operand selects
// Revision    : 1.0  initial release
// ============================================================================
module forwarding_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] i_id_ex_rs,
    input  logic [4:0] i_id_ex_rt,
    input  logic       i_ex_mem_reg_write,
    input  logic [4:0] i_ex_mem_wb_reg,
    input  logic       i_mem_wb_reg_write,
    input  logic [4:0] i_mem_wb_wb_reg,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    always_comb begin
        o_fwd_a = FWD_RF;
        if (fwd_hit(i_ex_mem_reg_write, i_ex_mem_wb_reg, i_id_ex_rs)) begin
            o_fwd_a = FWD_EXMEM;
        end else if (fwd_hit(i_mem_wb_reg_write, i_mem_wb_wb_reg, i_id_ex_rs)) begin
            o_fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        o_fwd_b = FWD_RF;
        if (fwd_hit(i_ex_mem_reg_write, i_ex_mem_wb_reg, i_id_ex_rt)) begin
            o_fwd_b = FWD_EXMEM;
        end else if (fwd_hit(i_mem_wb_reg_write, i_mem_wb_wb_reg, i_id_ex_rt)) begin
            o_fwd_b = FWD_MEMWB;
        end
    end

endmodule : forwarding_unit
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Pipeline control for the 5-stage core. Generates the PC and
//               stage-register write enables and bubble (flush) controls for
//               load-use stalls, taken branch/jump redirects resolved in MEM,
//               and multi-cycle data-memory waits. Also supplies the EX
//               forwarding selects, saturating stall/flush event counters and
//               a sticky memory-wait timeout flag.
// Ports       : clk, reset (async, active-low)
//               if_id_*  / id_ex_*      consumer-side register numbers
//               ex_mem_* / mem_wb_*     producer / control info downstream
//               mem_ready               data memory completes this cycle
//               *_WriteEn, *_flush      stage register controls
//               fwdA, fwdB              ALU operand selects
//               stall_cnt, flush_cnt    saturating event counters
//               mem_timeout             sticky wait-timeout flag
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [4:0]       id_ex_rs,
    input  logic [4:0]       id_ex_rt,
    input  logic             id_ex_MemRead,
    input  logic             ex_mem_Branch,
    input  logic             ex_mem_Jump,
    input  logic             ex_mem_Zero,
    input  logic             ex_mem_MemRead,
    input  logic             ex_mem_MemWrite,
    input  logic             ex_mem_RegWrite,
    input  logic [4:0]       ex_mem_WriteBackReg,
    input  logic             mem_wb_RegWrite,
    input  logic [4:0]       mem_wb_WriteBackReg,
    input  logic             mem_ready,
    output logic             pc_WriteEn,
    output logic             if_id_WriteEn,
    output logic             id_ex_WriteEn,
    output logic             ex_mem_WriteEn,
    output logic             mem_wb_WriteEn,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    // Wait counter saturates at MEM_TIMEOUT, so it only needs to hold that.
    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e             r_state_q;
    logic [WAIT_W-1:0]  r_wait_q;
    logic               r_timeout_q;
    logic [CNT_W-1:0]   r_stall_cnt_q;
    logic [CNT_W-1:0]   r_flush_cnt_q;

    state_e             w_state_d;
    logic [WAIT_W-1:0]  w_wait_d;
    logic               w_timeout_d;
    logic [CNT_W-1:0]   w_stall_cnt_d;
    logic [CNT_W-1:0]   w_flush_cnt_d;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    logic w_mem_busy;
    logic w_redirect;
    logic w_load_use;

    assign w_mem_busy = (ex_mem_MemRead | ex_mem_MemWrite) & ~mem_ready;
    assign w_redirect = ex_mem_Jump | (ex_mem_Branch & ex_mem_Zero);
    assign w_load_use = id_ex_MemRead && (id_ex_rt != 5'd0) &&
                        ((id_ex_rt == if_id_rs) ||
                         (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    // Raw (pre-reset-gating) controls
    logic       w_pc_we;
    logic       w_if_id_we;
    logic       w_id_ex_we;
    logic       w_ex_mem_we;
    logic       w_mem_wb_we;
    logic       w_if_id_fl;
    logic       w_id_ex_fl;
    logic       w_ex_mem_fl;
    logic       w_mem_wb_fl;
    logic       w_stall_inc;
    logic       w_flush_inc;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = RUN;
        w_wait_d    = '0;
        w_timeout_d = r_timeout_q;
        w_pc_we     = 1'b1;
        w_if_id_we  = 1'b1;
        w_id_ex_we  = 1'b1;
        w_ex_mem_we = 1'b1;
        w_mem_wb_we = 1'b1;
        w_if_id_fl  = 1'b0;
        w_id_ex_fl  = 1'b0;
        w_ex_mem_fl = 1'b0;
        w_mem_wb_fl = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;

        if (w_mem_busy) begin
            // Freeze everything up to EX/MEM and bubble into WB while the
            // memory access is outstanding.
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_id_ex_we  = 1'b0;
            w_ex_mem_we = 1'b0;
            w_mem_wb_we = 1'b0;
            w_mem_wb_fl = 1'b1;
            w_stall_inc = 1'b1;
            w_state_d   = MEM_WAIT;
            w_wait_d    = (r_wait_q == WAIT_MAX) ? r_wait_q : r_wait_q + WAIT_W'(1);
            if (w_wait_d >= WAIT_MAX) begin
                w_timeout_d = 1'b1;
            end
        end else if (w_redirect && (r_state_q != FLUSH)) begin
            // The three younger stages hold wrong-path instructions. The
            // cycle after a redirect those stages are already bubbles, so a
            // hazard seen then comes from garbage and is ignored.
            w_if_id_we  = 1'b0;
            w_id_ex_we  = 1'b0;
            w_ex_mem_we = 1'b0;
            w_if_id_fl  = 1'b1;
            w_id_ex_fl  = 1'b1;
            w_ex_mem_fl = 1'b1;
            w_flush_inc = 1'b1;
            w_state_d   = FLUSH;
        end else if (w_load_use && (r_state_q != FLUSH)) begin
            // Hold PC and IF/ID one cycle; a bubble enters ID/EX, which
            // removes the load from ID/EX and clears the condition.
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_id_ex_we  = 1'b0;
            w_id_ex_fl  = 1'b1;
            w_stall_inc = 1'b1;
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (w_stall_inc && (r_stall_cnt_q != '1)) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
        if (w_flush_inc && (r_flush_cnt_q != '1)) begin
            w_flush_cnt_d = r_flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q     <= RUN;
            r_wait_q      <= '0;
            r_timeout_q   <= 1'b0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_wait_q      <= w_wait_d;
            r_timeout_q   <= w_timeout_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    forwarding_unit u_forwarding_unit (
        .i_id_ex_rs         (id_ex_rs),
        .i_id_ex_rt         (id_ex_rt),
        .i_ex_mem_reg_write (ex_mem_RegWrite),
        .i_ex_mem_wb_reg    (ex_mem_WriteBackReg),
        .i_mem_wb_reg_write (mem_wb_RegWrite),
        .i_mem_wb_wb_reg    (mem_wb_WriteBackReg),
        .o_fwd_a            (w_fwd_a),
        .o_fwd_b            (w_fwd_b)
    );

    // ------------------------------------------------------------------
    // Outputs. While reset is low every stage is held cleared and nothing
    // is written, independent of the clock.
    // ------------------------------------------------------------------
    assign pc_WriteEn     = reset & w_pc_we;
    assign if_id_WriteEn  = reset & w_if_id_we;
    assign id_ex_WriteEn  = reset & w_id_ex_we;
    assign ex_mem_WriteEn = reset & w_ex_mem_we;
    assign mem_wb_WriteEn = reset & w_mem_wb_we;
    assign if_id_flush    = ~reset | w_if_id_fl;
    assign id_ex_flush    = ~reset | w_id_ex_fl;
    assign ex_mem_flush   = ~reset | w_ex_mem_fl;
    assign mem_wb_flush   = ~reset | w_mem_wb_fl;
    assign fwdA           = reset ? w_fwd_a : FWD_RF;
    assign fwdB           = reset ? w_fwd_b : FWD_RF;
    assign stall_cnt      = r_stall_cnt_q;
    assign flush_cnt      = r_flush_cnt_q;
    assign mem_timeout    = r_timeout_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. A driver issues
//               one stimulus vector per cycle, derives the expected controls
//               from a behavioural model and queues them; a monitor compares
//               the DUT against the queue on every falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 6;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] ifid_rs, ifid_rt;
        logic       uses_rt;
        logic [4:0] idex_rs, idex_rt;
        logic       idex_mr;
        logic       branch, jump, zero;
        logic       mr, mw;
        logic       exwr;
        logic [4:0] exreg;
        logic       wbwr;
        logic [4:0] wbreg;
        logic       ready;
    } stim_t;

    // ctl = {pc, we_ifid, we_idex, we_exmem, we_memwb, fl_ifid, fl_idex, fl_exmem, fl_memwb}
    typedef struct {
        logic [8:0]       ctl;
        logic [1:0]       fa, fb;
        logic [CNT_W-1:0] sc, fc;
        logic             to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, ex_mem_WriteBackReg, mem_wb_WriteBackReg;
    logic if_id_uses_rt, id_ex_MemRead, ex_mem_Branch, ex_mem_Jump, ex_mem_Zero;
    logic ex_mem_MemRead, ex_mem_MemWrite, ex_mem_RegWrite, mem_wb_RegWrite, mem_ready;
    logic pc_WriteEn, if_id_WriteEn, id_ex_WriteEn, ex_mem_WriteEn, mem_wb_WriteEn;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] fwdA, fwdB;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_timeout;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_MemRead(id_ex_MemRead),
        .ex_mem_Branch(ex_mem_Branch), .ex_mem_Jump(ex_mem_Jump), .ex_mem_Zero(ex_mem_Zero),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_WriteBackReg(ex_mem_WriteBackReg),
        .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_WriteBackReg(mem_wb_WriteBackReg),
        .mem_ready(mem_ready),
        .pc_WriteEn(pc_WriteEn), .if_id_WriteEn(if_id_WriteEn), .id_ex_WriteEn(id_ex_WriteEn),
        .ex_mem_WriteEn(ex_mem_WriteEn), .mem_wb_WriteEn(mem_wb_WriteEn),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    // Behavioural model state
    bit m_after_redirect;
    int m_wait_run;
    bit m_to;
    int m_sc, m_fc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctl", 32'({pc_WriteEn, if_id_WriteEn, id_ex_WriteEn, ex_mem_WriteEn, mem_wb_WriteEn,
                              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}), 32'(e.ctl));
            check("fwdA", 32'(fwdA), 32'(e.fa));
            check("fwdB", 32'(fwdB), 32'(e.fb));
            check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
            check("flush_cnt", 32'(flush_cnt), 32'(e.fc));
            check("mem_timeout", 32'(mem_timeout), 32'(e.to));
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{ifid_rs:0, ifid_rt:0, uses_rt:0, idex_rs:0, idex_rt:0, idex_mr:0,
              branch:0, jump:0, zero:0, mr:0, mw:0, exwr:0, exreg:0, wbwr:0, wbreg:0, ready:1};
        return s;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input stim_t s);
        if (s.exwr && s.exreg != 0 && s.exreg == src) return 2'b10;
        if (s.wbwr && s.wbreg != 0 && s.wbreg == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input stim_t s);
        if_id_rs = s.ifid_rs; if_id_rt = s.ifid_rt; if_id_uses_rt = s.uses_rt;
        id_ex_rs = s.idex_rs; id_ex_rt = s.idex_rt; id_ex_MemRead = s.idex_mr;
        ex_mem_Branch = s.branch; ex_mem_Jump = s.jump; ex_mem_Zero = s.zero;
        ex_mem_MemRead = s.mr; ex_mem_MemWrite = s.mw;
        ex_mem_RegWrite = s.exwr; ex_mem_WriteBackReg = s.exreg;
        mem_wb_RegWrite = s.wbwr; mem_wb_WriteBackReg = s.wbreg;
        mem_ready = s.ready;
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.ctl = 9'b0_0000_1111; e.fa = 2'b00; e.fb = 2'b00;
        e.sc = '0; e.fc = '0; e.to = 1'b0;
        return e;
    endfunction

    function automatic void model_reset();
        m_after_redirect = 0; m_wait_run = 0; m_to = 0; m_sc = 0; m_fc = 0;
    endfunction

    // One pipeline cycle: apply inputs, queue the expected response,
    // advance one clock and update the model.
    task automatic step(input stim_t s);
        exp_t e;
        bit busy, redir, lu, took_redirect, stall_ev;
        drive(s);
        busy  = (s.mr || s.mw) && !s.ready;
        redir = s.jump || (s.branch && s.zero);
        lu    = s.idex_mr && s.idex_rt != 0 &&
                (s.idex_rt == s.ifid_rs || (s.uses_rt && s.idex_rt == s.ifid_rt));
        e.fa = fwd_sel(s.idex_rs, s);
        e.fb = fwd_sel(s.idex_rt, s);
        e.sc = CNT_W'(m_sc); e.fc = CNT_W'(m_fc); e.to = m_to;
        took_redirect = 0; stall_ev = 0;
        if (busy) begin
            e.ctl = 9'b0_0000_0001; stall_ev = 1;
        end else if (redir && !m_after_redirect) begin
            e.ctl = 9'b1_0001_1110; took_redirect = 1;
        end else if (lu && !m_after_redirect) begin
            e.ctl = 9'b0_0011_0100; stall_ev = 1;
        end else begin
            e.ctl = 9'b1_1111_0000;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        m_after_redirect = took_redirect;
        if (busy) begin
            m_wait_run++;
            if (m_wait_run >= MEM_TIMEOUT) m_to = 1;
        end else begin
            m_wait_run = 0;
        end
        if (stall_ev && m_sc < CNT_MAX) m_sc++;
        if (took_redirect && m_fc < CNT_MAX) m_fc++;
    endtask

    // Pull reset low between edges; outputs must collapse immediately.
    task automatic async_reset();
        reset = 1'b0;
        model_reset();
        exp_q.push_back(reset_exp());
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        reset = 1'b0;
        drive(idle());
        model_reset();
        #1;
        exp_q.push_back(reset_exp());
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;

        // Load-use, then recovery
        s = idle(); s.idex_mr = 1; s.idex_rt = 5; s.ifid_rs = 5;
        step(s);
        step(idle());

        // Taken branch; load-use right after is wrong-path and ignored
        s = idle(); s.branch = 1; s.zero = 1;
        step(s);
        s = idle(); s.idex_mr = 1; s.idex_rt = 5; s.ifid_rs = 5;
        step(s);
        step(idle());

        // Three-cycle memory wait
        s = idle(); s.mr = 1; s.ready = 0;
        repeat (3) step(s);
        s.ready = 1;
        step(s);
        step(idle());

        // Timeout: six wait cycles, flag must persist afterwards
        s = idle(); s.mw = 1; s.ready = 0;
        repeat (6) step(s);
        s.ready = 1;
        step(s);
        repeat (2) step(idle());

        // Forwarding priority and r0 exclusion
        s = idle(); s.exwr = 1; s.exreg = 7; s.wbwr = 1; s.wbreg = 7; s.idex_rs = 7; s.idex_rt = 7;
        step(s);
        s.exreg = 0; s.wbreg = 0; s.idex_rs = 0; s.idex_rt = 0;
        step(s);
        s = idle(); s.wbwr = 1; s.wbreg = 9; s.idex_rt = 9;
        step(s);

        // Async reset in the middle of a memory wait
        s = idle(); s.mr = 1; s.ready = 0;
        repeat (2) step(s);
        async_reset();
        repeat (2) step(idle());

        // Randomized traffic (long enough to saturate the counters)
        for (int i = 0; i < 700; i++) begin
            s.ifid_rs = 5'($urandom_range(0, 3));
            s.ifid_rt = 5'($urandom_range(0, 3));
            s.uses_rt = ($urandom_range(0, 99) < 50);
            s.idex_rs = 5'($urandom_range(0, 3));
            s.idex_rt = 5'($urandom_range(0, 3));
            s.idex_mr = ($urandom_range(0, 99) < 40);
            s.branch  = ($urandom_range(0, 99) < 20);
            s.jump    = ($urandom_range(0, 99) < 8);
            s.zero    = ($urandom_range(0, 99) < 50);
            s.mr      = ($urandom_range(0, 99) < 25);
            s.mw      = ($urandom_range(0, 99) < 15);
            s.exwr    = ($urandom_range(0, 99) < 60);
            s.exreg   = 5'($urandom_range(0, 3));
            s.wbwr    = ($urandom_range(0, 99) < 60);
            s.wbreg   = 5'($urandom_range(0, 3));
            s.ready   = ($urandom_range(0, 99) < 75);
            step(s);
        end

        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
